mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares a single memory bus between the instruction-fetch and data-access requesters of the request unit.
- Data accesses get priority; a streak counter guarantees fetch progress; a watchdog aborts hung bus transactions.
- Sits between the request unit (requester side) and the memory controller (bus side).
- Sequences one transaction at a time through a registered FSM.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive data grants while fetch is pending
- TIMEOUT, 64, cycles without busAck before abort

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- imemRen  in  1  fetch request; held until i_ready
- imemaddr  in  ADDR_W  fetch address
- dmmRen  in  1  data read request; held until d_ready
- dmmWen  in  1  data write request; held until d_ready
- dmmaddr  in  ADDR_W  data address
- dmmstore  in  DATA_W  write data
- d_fetch  in  4  byte enables for data access
- i_ready  out  1  one-cycle fetch-complete pulse
- d_ready  out  1  one-cycle data-complete pulse
- imemload  out  DATA_W  fetched instruction, valid with i_ready
- dmmload  out  DATA_W  read data, valid with d_ready
- busRen  out  1  bus read strobe
- busWen  out  1  bus write strobe
- busAddr  out  ADDR_W  bus address
- busWdata  out  DATA_W  bus write data
- busSel  out  4  bus byte enables
- busRdata  in  DATA_W  bus read data, valid with busAck
- busAck  in  1  one-cycle completion pulse from bus
- busErr  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, nRst=0):
  - State IDLE.
  - All outputs 0; imemload and dmmload 0.
  - Streak and timeout counters 0.
  - Lockout flags cleared.
  - Any in-flight transaction is dropped with no ready pulse.
- States: IDLE, IBUSY, DBUSY. All outputs are registered.
- IDLE grant rule, evaluated each cycle:
  - dreq = (dmmRen|dmmWen) & !dlock
  - ireq = imemRen & !ilock
  - If dreq & !(ireq & streak==STARVE_LIMIT): go to DBUSY.
    - Latch dmmaddr, dmmstore and d_fetch onto the bus outputs.
    - busWen=dmmWen. busRen=dmmRen&!dmmWen (write wins if both are high).
    - streak increments if imemRen, else clears.
  - Else if ireq: go to IBUSY.
    - busRen=1, busAddr=imemaddr, busSel=4'hF. streak clears.
  - Else stay in IDLE.
- Strobes stay high for the whole BUSY state; address and data are stable from grant to completion.
- Completion (busAck in xBUSY):
  - Strobes drop; return to IDLE.
  - Next cycle: the matching ready pulses for 1 cycle. dmmload/imemload take busRdata (reads only); dmmload is unchanged on writes.
- Lockout: ilock/dlock is set for the single cycle in which that port's ready is high. No re-grant of a port while its ready is asserted, so a requester still holding its request does not issue a duplicate.
- Latency:
  - Request at cycle 0 → strobe at cycle 1 → busAck at cycle k≥1 → ready at cycle k+1.
  - Minimum turnaround is 3 cycles per transaction.
- Timeout:
  - Counter clears on grant and increments each cycle in xBUSY.
  - If it reaches TIMEOUT with no busAck: abort to IDLE and drop strobes.
  - Next cycle: pulse the matching ready and busErr together; load value = 32'hBAD0_BAD0.
- busAck in IDLE is ignored.
- Requester deasserts mid-transaction: the transaction still completes and ready still pulses.
- Simultaneous busAck and timeout terminal count: busAck wins, no busErr.

Test Plan:
- Reset, idle: hold nRst=0 with requests active → all outputs 0. Release with no requests → no strobes for 10 cycles.
- Single fetch: imemRen, addr 0x100, busAck at cycle 3 with 0x00500093 → busRen high cycles 1–3, i_ready pulse at cycle 4, imemload=0x00500093.
- Contention: imemRen and dmmRen raised together at cycle 0 → data granted first, fetch granted in the IDLE after d_ready. Each transaction completes within 3 cycles when busAck follows 1 cycle after the strobe.
- Starvation: imemRen held; dmmWen re-asserted after each d_ready → exactly 4 data grants, then a fetch grant, then streak restarts.
- Write with byte select: dmmWen=dmmRen=1, d_fetch=4'b0011, data 0xDEADBEEF, addr 0x2000 → busWen=1, busRen=0, busSel=0011. d_ready pulses; dmmload is unchanged.
- Timeout and reset: no busAck for 64 cycles → abort, d_ready and busErr pulse with dmmload=0xBAD0BAD0. Separately, nRst low mid-DBUSY → no ready pulse, IDLE on release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory bus arbiter: runs one transaction at a time for the instruction-fetch and data ports.
// Data wins by default, a grant-streak limit keeps fetch moving, and a watchdog aborts hung transfers.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              imemRen,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmmRen,
    input  logic              dmmWen,
    input  logic [ADDR_W-1:0] dmmaddr,
    input  logic [DATA_W-1:0] dmmstore,
    input  logic [3:0]        d_fetch,
    output logic              i_ready,
    output logic              d_ready,
    output logic [DATA_W-1:0] imemload,
    output logic [DATA_W-1:0] dmmload,
    output logic              busRen,
    output logic              busWen,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWdata,
    output logic [3:0]        busSel,
    input  logic [DATA_W-1:0] busRdata,
    input  logic              busAck,
    output logic              busErr
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0]   ABORT_WORD = DATA_W'(32'hBAD0_BAD0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [TCNT_W-1:0]   tcnt;
    logic                ilock;
    logic                dlock;

    logic dreq;
    logic ireq;
    logic fetch_turn;
    logic timed_out;

    // A port is locked out during its own ready cycle so a held request is not serviced twice.
    assign dreq       = (dmmRen | dmmWen) & ~dlock;
    assign ireq       = imemRen & ~ilock;
    assign fetch_turn = ireq & (streak == STREAK_MAX);
    assign timed_out  = (tcnt == TCNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            streak   <= '0;
            tcnt     <= '0;
            ilock    <= 1'b0;
            dlock    <= 1'b0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
            busErr   <= 1'b0;
            imemload <= '0;
            dmmload  <= '0;
            busRen   <= 1'b0;
            busWen   <= 1'b0;
            busAddr  <= '0;
            busWdata <= '0;
            busSel   <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only a completion raises them, so each lasts one clock.
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            busErr  <= 1'b0;
            ilock   <= 1'b0;
            dlock   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (dreq && !fetch_turn) begin
                        state    <= DBUSY;
                        tcnt     <= '0;
                        busAddr  <= dmmaddr;
                        busWdata <= dmmstore;
                        busSel   <= d_fetch;
                        busWen   <= dmmWen;
                        busRen   <= dmmRen & ~dmmWen;
                        // Streak counts data grants that overtook a waiting fetch.
                        if (!imemRen) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (ireq) begin
                        state   <= IBUSY;
                        tcnt    <= '0;
                        streak  <= '0;
                        busAddr <= imemaddr;
                        busSel  <= 4'hF;
                        busRen  <= 1'b1;
                        busWen  <= 1'b0;
                    end
                end

                IBUSY, DBUSY: begin
                    if (busAck || timed_out) begin
                        // An acknowledge on the terminal watchdog cycle still counts as success.
                        state  <= IDLE;
                        busRen <= 1'b0;
                        busWen <= 1'b0;
                        busErr <= ~busAck;
                        if (state == IBUSY) begin
                            i_ready  <= 1'b1;
                            ilock    <= 1'b1;
                            imemload <= busAck ? busRdata : ABORT_WORD;
                        end else begin
                            d_ready <= 1'b1;
                            dlock   <= 1'b1;
                            if (!busAck) begin
                                dmmload <= ABORT_WORD;
                            end else if (busRen) begin
                                dmmload <= busRdata;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    busRen <= 1'b0;
                    busWen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then randomized requesters and bus,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;
    localparam logic [31:0] BAD_WORD = 32'hBAD0_BAD0;

    logic        clk;
    logic        nRst;
    logic        imemRen;
    logic [31:0] imemaddr;
    logic        dmmRen;
    logic        dmmWen;
    logic [31:0] dmmaddr;
    logic [31:0] dmmstore;
    logic [3:0]  d_fetch;
    logic        i_ready;
    logic        d_ready;
    logic [31:0] imemload;
    logic [31:0] dmmload;
    logic        busRen;
    logic        busWen;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busSel;
    logic [31:0] busRdata;
    logic        busAck;
    logic        busErr;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .imemRen(imemRen),
        .imemaddr(imemaddr),
        .dmmRen(dmmRen),
        .dmmWen(dmmWen),
        .dmmaddr(dmmaddr),
        .dmmstore(dmmstore),
        .d_fetch(d_fetch),
        .i_ready(i_ready),
        .d_ready(d_ready),
        .imemload(imemload),
        .dmmload(dmmload),
        .busRen(busRen),
        .busWen(busWen),
        .busAddr(busAddr),
        .busWdata(busWdata),
        .busSel(busSel),
        .busRdata(busRdata),
        .busAck(busAck),
        .busErr(busErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the transaction currently on the bus plus the visible result registers.
    typedef struct {
        bit          is_data;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } txn_t;

    bit          m_busy;
    txn_t        m_cur;
    int          m_age;
    int          m_streak;
    logic        e_ren, e_wen, e_iready, e_dready, e_err;
    logic [31:0] e_addr, e_wdata, e_iload, e_dload;
    logic [3:0]  e_sel;

    // Bus-side and requester-side stimulus controls.
    int          fixed_lat;
    int          cur_lat;
    bit          rdata_rand;
    logic [31:0] rdata_val;
    bit          spurious;
    bit          i_act, d_act, i_drop_next, d_drop_next;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_age    = 0;
        m_streak = 0;
        e_ren    = 0;
        e_wen    = 0;
        e_iready = 0;
        e_dready = 0;
        e_err    = 0;
        e_addr   = '0;
        e_wdata  = '0;
        e_sel    = '0;
        e_iload  = '0;
        e_dload  = '0;
    endtask

    // Applies the arbitration rules to the inputs present just before a rising edge.
    task automatic model_edge();
        bit ni, nd, ne, dreq, ireq;
        ni = 0;
        nd = 0;
        ne = 0;
        if (m_busy) begin
            m_age++;
            if (busAck || m_age >= TIMEOUT) begin
                if (m_cur.is_data) begin
                    nd = 1;
                    if (!busAck) e_dload = BAD_WORD;
                    else if (m_cur.ren) e_dload = busRdata;
                end else begin
                    ni = 1;
                    e_iload = busAck ? busRdata : BAD_WORD;
                end
                ne     = !busAck;
                m_busy = 0;
                e_ren  = 0;
                e_wen  = 0;
            end
        end else begin
            dreq = (dmmRen || dmmWen) && !e_dready;
            ireq = imemRen && !e_iready;
            if (dreq && !(ireq && m_streak >= STARVE_LIMIT)) begin
                m_cur.is_data = 1;
                m_cur.wen     = dmmWen;
                m_cur.ren     = dmmRen && !dmmWen;
                m_cur.addr    = dmmaddr;
                m_cur.wdata   = dmmstore;
                m_cur.sel     = d_fetch;
                m_streak      = imemRen ? m_streak + 1 : 0;
                m_busy        = 1;
            end else if (ireq) begin
                m_cur.is_data = 0;
                m_cur.wen     = 0;
                m_cur.ren     = 1;
                m_cur.addr    = imemaddr;
                m_cur.wdata   = '0;
                m_cur.sel     = 4'hF;
                m_streak      = 0;
                m_busy        = 1;
            end
            if (m_busy) begin
                m_age   = 0;
                e_ren   = m_cur.ren;
                e_wen   = m_cur.wen;
                e_addr  = m_cur.addr;
                e_wdata = m_cur.wdata;
                e_sel   = m_cur.sel;
            end
        end
        e_iready = ni;
        e_dready = nd;
        e_err    = ne;
    endtask

    task automatic compare();
        check("busRen", busRen, e_ren);
        check("busWen", busWen, e_wen);
        check("i_ready", i_ready, e_iready);
        check("d_ready", d_ready, e_dready);
        check("busErr", busErr, e_err);
        check("imemload", imemload, e_iload);
        check("dmmload", dmmload, e_dload);
        if (e_ren || e_wen) begin
            check("busAddr", busAddr, e_addr);
            check("busSel", busSel, e_sel);
        end
        if (e_wen) check("busWdata", busWdata, e_wdata);
    endtask

    function automatic int pick_lat();
        if (fixed_lat >= 0) return fixed_lat;
        if ($urandom_range(0, 49) == 0) return 0;
        return int'($urandom_range(1, 4));
    endfunction

    // Memory controller: acknowledges after cur_lat strobe cycles (0 = never).
    task automatic drive_ack();
        if (m_busy) busAck = (m_age + 1 == cur_lat);
        else        busAck = spurious && ($urandom_range(0, 9) == 0);
        busRdata = rdata_rand ? $urandom : rdata_val;
    endtask

    task automatic tick();
        bit was_busy;
        drive_ack();
        was_busy = m_busy;
        model_edge();
        if (!was_busy && m_busy) cur_lat = pick_lat();
        @(negedge clk);
        compare();
    endtask

    // Random requesters: hold until ready (sometimes one cycle longer), occasionally withdraw.
    task automatic req_step();
        if (i_act) begin
            if (i_drop_next || $urandom_range(0, 59) == 0) begin
                i_act       = 0;
                i_drop_next = 0;
            end else if (i_ready) begin
                if ($urandom_range(0, 1) == 1) i_act = 0;
                else i_drop_next = 1;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            i_act    = 1;
            imemaddr = $urandom & 32'hFFFF_FFFC;
        end
        imemRen = i_act;

        if (d_act) begin
            if (d_drop_next || $urandom_range(0, 59) == 0) begin
                d_act       = 0;
                d_drop_next = 0;
            end else if (d_ready) begin
                if ($urandom_range(0, 1) == 1) d_act = 0;
                else d_drop_next = 1;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            int kind;
            kind     = int'($urandom_range(0, 2));
            d_act    = 1;
            dmmRen   = (kind != 1);
            dmmWen   = (kind != 0);
            dmmaddr  = $urandom & 32'hFFFF_FFFC;
            dmmstore = $urandom;
            d_fetch  = 4'($urandom_range(1, 15));
        end
        if (!d_act) begin
            dmmRen = 0;
            dmmWen = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        bit exp_first[6];

        // Reset with requests active: every output must sit at zero.
        nRst       = 0;
        imemRen    = 1;
        dmmRen     = 1;
        dmmWen     = 0;
        imemaddr   = 32'h44;
        dmmaddr    = 32'h88;
        dmmstore   = 32'hFFFF_FFFF;
        d_fetch    = 4'hF;
        busAck     = 1;
        busRdata   = 32'hFFFF_FFFF;
        fixed_lat  = 1;
        cur_lat    = 0;
        rdata_rand = 0;
        rdata_val  = '0;
        spurious   = 0;
        i_act = 0; d_act = 0; i_drop_next = 0; d_drop_next = 0;
        repeat (3) @(negedge clk);
        check("rst_busRen", busRen, 0);
        check("rst_busWen", busWen, 0);
        check("rst_busErr", busErr, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_busAddr", busAddr, 0);
        check("rst_busSel", busSel, 0);
        check("rst_busWdata", busWdata, 0);
        check("rst_imemload", imemload, 0);
        check("rst_dmmload", dmmload, 0);
        imemRen = 0;
        dmmRen  = 0;
        nRst    = 1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_no_strobe", busRen | busWen, 0);
        end

        // Single fetch, acknowledged on the third strobe cycle.
        fixed_lat = 3;
        rdata_val = 32'h0050_0093;
        imemaddr  = 32'h100;
        imemRen   = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("fetch_ren", busRen, (c >= 1 && c <= 3));
            check("fetch_rdy", i_ready, c == 4);
            if (c == 1) check("fetch_addr", busAddr, 32'h100);
            if (c == 4) check("fetch_load", imemload, 32'h0050_0093);
            if (i_ready) imemRen = 0;
        end

        // Contention: data first; data requester holds through its ready cycle.
        fixed_lat = 1;
        rdata_val = 32'hA5A5_0001;
        imemaddr  = 32'h104;
        dmmaddr   = 32'h3000;
        d_fetch   = 4'hF;
        dmmRen    = 1;
        dmmWen    = 0;
        imemRen   = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("cont_ren", busRen, (c == 1 || c == 3));
            check("cont_d_rdy", d_ready, c == 2);
            check("cont_i_rdy", i_ready, c == 4);
            if (c == 1) check("cont_daddr", busAddr, 32'h3000);
            if (c == 3) check("cont_iaddr", busAddr, 32'h104);
            if (c == 3) dmmRen = 0;
            if (i_ready) imemRen = 0;
        end

        // Starvation: four data grants overtake the fetch, then fetch, then the streak restarts.
        exp_first = '{1, 1, 1, 1, 0, 1};
        for (int r = 0; r < 6; r++) begin
            first    = -1;
            imemRen  = 1;
            dmmWen   = 1;
            dmmRen   = 0;
            imemaddr = 32'h200 + 32'(r * 4);
            dmmaddr  = 32'h4000 + 32'(r * 4);
            dmmstore = $urandom;
            for (int c = 0; c < 12 && (imemRen || dmmWen); c++) begin
                tick();
                if (first < 0 && (busRen || busWen)) first = int'(busWen);
                if (d_ready) begin
                    dmmWen  = 0;
                    imemRen = 0;
                end
                if (i_ready) imemRen = 0;
            end
            check("starve_first_is_data", first, exp_first[r]);
            check("starve_round_done", imemRen | dmmWen, 0);
            imemRen = 0;
            dmmWen  = 0;
            tick();
        end

        // Establish a known read value, then a byte-select write must leave it untouched.
        rdata_val = 32'h1234_5678;
        dmmaddr   = 32'h1000;
        dmmRen    = 1;
        for (int c = 0; c < 6 && dmmRen; c++) begin
            tick();
            if (d_ready) dmmRen = 0;
        end
        check("rd_load", dmmload, 32'h1234_5678);
        tick();
        rdata_val = 32'hFFFF_0000;
        dmmWen    = 1;
        dmmRen    = 1;
        d_fetch   = 4'b0011;
        dmmstore  = 32'hDEAD_BEEF;
        dmmaddr   = 32'h2000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                check("wr_wen", busWen, 1);
                check("wr_ren", busRen, 0);
                check("wr_sel", busSel, 4'b0011);
                check("wr_addr", busAddr, 32'h2000);
                check("wr_data", busWdata, 32'hDEAD_BEEF);
            end
            check("wr_rdy", d_ready, c == 2);
            if (c == 2) check("wr_load_kept", dmmload, 32'h1234_5678);
            if (d_ready) begin
                dmmWen = 0;
                dmmRen = 0;
            end
        end

        // Watchdog abort: no acknowledge at all.
        fixed_lat = 0;
        d_fetch   = 4'hF;
        dmmaddr   = 32'h5000;
        dmmRen    = 1;
        for (int c = 1; c <= 67; c++) begin
            tick();
            check("to_ren", busRen, c <= 64);
            check("to_err", busErr, c == 65);
            check("to_rdy", d_ready, c == 65);
            if (c == 65) check("to_load", dmmload, BAD_WORD);
            if (d_ready) dmmRen = 0;
        end

        // Acknowledge on the last watchdog cycle wins over the abort.
        fixed_lat = 64;
        rdata_val = 32'hC0DE_0064;
        imemaddr  = 32'h600;
        imemRen   = 1;
        for (int c = 1; c <= 66; c++) begin
            tick();
            check("ack64_err", busErr, 0);
            check("ack64_rdy", i_ready, c == 65);
            if (c == 65) check("ack64_load", imemload, 32'hC0DE_0064);
            if (i_ready) imemRen = 0;
        end

        // Reset in the middle of a data transaction: dropped without a ready pulse.
        fixed_lat = 0;
        dmmaddr   = 32'h7000;
        dmmRen    = 1;
        repeat (5) tick();
        nRst = 0;
        #1;
        check("rstmid_ren", busRen, 0);
        check("rstmid_rdy", d_ready, 0);
        check("rstmid_err", busErr, 0);
        model_reset();
        dmmRen = 0;
        busAck = 0;
        @(negedge clk);
        nRst = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rstmid_no_rdy", d_ready | i_ready | busErr, 0);
        end

        // Randomized traffic: random requesters, latencies, rare hangs and stray acknowledges.
        fixed_lat  = -1;
        rdata_rand = 1;
        spurious   = 1;
        for (int c = 0; c < 1500; c++) begin
            req_step();
            tick();
        end
        imemRen = 0;
        dmmRen  = 0;
        dmmWen  = 0;
        for (int c = 0; c < 140; c++) tick();
        check("drain_idle", busRen | busWen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
